// File: rtl/fc_argmax.sv
// Running argmax over one signed 8-bit score per class; presents winning class/score on valid/ready.
// Optional per-frame score buffer with 1-cycle read port when ARGMAX_SCORE_BUF_EN is defined.
module fc_argmax #(
   parameter int unsigned NUM_CLASSES = 10,
   parameter int unsigned CLS_W       = 4
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic signed [7:0]       i_score,
   input  logic                    i_score_valid,
   input  logic                    i_clear,
   output logic [CLS_W-1:0]        o_class,
   output logic [7:0]              o_max_score,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic                    o_busy,
   output logic                    o_overflow
`ifdef ARGMAX_SCORE_BUF_EN
   ,
   input  logic [CLS_W-1:0]        i_rd_addr,
   output logic [7:0]              o_rd_score
`endif
);

   localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(NUM_CLASSES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t             state;
   logic [CLS_W-1:0]   cnt;
   logic [CLS_W-1:0]   idx_q;
   logic signed [7:0]  max_q;

   logic               gt_c;
   logic signed [7:0]  nxt_max_c;
   logic [CLS_W-1:0]   nxt_idx_c;

   // Strict compare so ties keep the earlier (lower) class index
   always_comb begin
      gt_c      = 1'b0;
      nxt_max_c = max_q;
      nxt_idx_c = idx_q;
      if (i_score > max_q) begin
         gt_c      = 1'b1;
         nxt_max_c = i_score;
         nxt_idx_c = cnt;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         cnt         <= '0;
         idx_q       <= '0;
         max_q       <= '0;
         o_class     <= '0;
         o_max_score <= '0;
         o_valid     <= 1'b0;
         o_busy      <= 1'b0;
         o_overflow  <= 1'b0;
      end else if (i_clear) begin
         // Frame abort: discard partial frame, pending result and sticky overflow
         state       <= IDLE;
         cnt         <= '0;
         idx_q       <= '0;
         max_q       <= '0;
         o_class     <= '0;
         o_max_score <= '0;
         o_valid     <= 1'b0;
         o_busy      <= 1'b0;
         o_overflow  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_score_valid) begin
                  max_q  <= i_score;
                  idx_q  <= '0;
                  cnt    <= CLS_W'(1);
                  state  <= ACCUM;
                  o_busy <= 1'b1;
               end
            end
            ACCUM: begin
               if (i_score_valid) begin
                  max_q <= nxt_max_c;
                  idx_q <= nxt_idx_c;
                  if (cnt == LAST_IDX) begin
                     // Last score: publish the final compare result on this same edge
                     state       <= HOLD;
                     cnt         <= '0;
                     o_class     <= nxt_idx_c;
                     o_max_score <= nxt_max_c;
                     o_valid     <= 1'b1;
                     o_busy      <= 1'b0;
                  end else begin
                     cnt <= cnt + CLS_W'(1);
                  end
               end
            end
            HOLD: begin
               if (i_ready) begin
                  o_valid <= 1'b0;
                  if (i_score_valid) begin
                     max_q  <= i_score;
                     idx_q  <= '0;
                     cnt    <= CLS_W'(1);
                     state  <= ACCUM;
                     o_busy <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end else if (i_score_valid) begin
                  o_overflow <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef ARGMAX_SCORE_BUF_EN
   logic [7:0] score_buf [NUM_CLASSES];
   logic       accept_c;

   // cnt is 0 in IDLE and HOLD, so it is always the slot of the accepted score
   assign accept_c = i_score_valid && !i_clear && ((state != HOLD) || i_ready);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < int'(NUM_CLASSES); i++) score_buf[i] <= '0;
         o_rd_score <= '0;
      end else begin
         if (i_clear) begin
            for (int i = 0; i < int'(NUM_CLASSES); i++) score_buf[i] <= '0;
         end else if (accept_c) begin
            score_buf[cnt] <= i_score;
         end
         o_rd_score <= (i_rd_addr <= LAST_IDX) ? score_buf[i_rd_addr] : 8'd0;
      end
   end
`endif

endmodule

// File: tb/tb_fc_argmax.sv
// Directed bench for fc_argmax: expected results come from a bench-side argmax model
// pushed into a scoreboard queue and popped when the DUT presents o_valid.
module tb_fc_argmax;

   typedef logic signed [7:0] frame_t [10];
   typedef struct packed {
      logic [3:0] cls;
      logic [7:0] sc;
   } exp_t;

   logic              clk = 1'b0;
   logic              resetn;
   logic signed [7:0] i_score;
   logic              i_score_valid;
   logic              i_clear;
   logic [3:0]        o_class;
   logic [7:0]        o_max_score;
   logic              o_valid;
   logic              i_ready;
   logic              o_busy;
   logic              o_overflow;
`ifdef ARGMAX_SCORE_BUF_EN
   logic [3:0]        i_rd_addr;
   logic [7:0]        o_rd_score;
`endif

   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];

   fc_argmax #(.NUM_CLASSES(10), .CLS_W(4)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .i_score       (i_score),
      .i_score_valid (i_score_valid),
      .i_clear       (i_clear),
      .o_class       (o_class),
      .o_max_score   (o_max_score),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_busy        (o_busy),
      .o_overflow    (o_overflow)
`ifdef ARGMAX_SCORE_BUF_EN
      ,
      .i_rd_addr     (i_rd_addr),
      .o_rd_score    (o_rd_score)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic frame_t mk(input int v [10]);
      frame_t r;
      for (int i = 0; i < 10; i++) r[i] = 8'(v[i]);
      return r;
   endfunction

   function automatic exp_t model(input frame_t f);
      exp_t e;
      e.cls = 4'd0;
      e.sc  = f[0];
      for (int i = 1; i < 10; i++) begin
         if (f[i] > $signed(e.sc)) begin
            e.cls = 4'(i);
            e.sc  = f[i];
         end
      end
      return e;
   endfunction

   task automatic pop_check(input string tag);
      exp_t e;
      check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({tag, "_class"}, 32'(o_class), 32'(e.cls));
         check({tag, "_score"}, 32'(o_max_score), 32'(e.sc));
      end
   endtask

   task automatic run_frame(input frame_t f, input logic rdy);
      exp_q.push_back(model(f));
      i_ready = rdy;
      for (int i = 0; i < 10; i++) begin
         i_score       = f[i];
         i_score_valid = 1'b1;
         tick();
         if (i == 0) check("busy_accum", 32'(o_busy), 32'd1);
      end
      i_score_valid = 1'b0;
   endtask

   frame_t f;
   int     v [10];
   exp_t   held;

   initial begin
      resetn        = 1'b0;
      i_score       = '0;
      i_score_valid = 1'b0;
      i_clear       = 1'b0;
      i_ready       = 1'b1;
`ifdef ARGMAX_SCORE_BUF_EN
      i_rd_addr     = '0;
`endif
      tick();
      tick();
      resetn = 1'b1;
      tick();
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_ovf", 32'(o_overflow), 32'd0);
      check("rst_class", 32'(o_class), 32'd0);
      check("rst_score", 32'(o_max_score), 32'd0);

      // Ascending ramp 0..90, result one cycle after the 10th score
      for (int i = 0; i < 10; i++) v[i] = i * 10;
      f = mk(v);
      run_frame(f, 1'b1);
      check("ramp_valid", 32'(o_valid), 32'd1);
      check("ramp_busy", 32'(o_busy), 32'd0);
      pop_check("ramp");
      tick();
      check("ramp_valid_drop", 32'(o_valid), 32'd0);

      // Ties keep lowest index, extremes compared signed
      v = '{-5, -5, 3, 3, -128, 127, 127, 0, 0, 0};
      f = mk(v);
      run_frame(f, 1'b1);
      check("tie_valid", 32'(o_valid), 32'd1);
      pop_check("tie");
      tick();

      // All minimum scores
      for (int i = 0; i < 10; i++) v[i] = -128;
      f = mk(v);
      run_frame(f, 1'b1);
      check("min_valid", 32'(o_valid), 32'd1);
      pop_check("min");
      tick();

      // Backpressure with dropped scores, then handshake carrying the next frame's first score
      v = '{3, 8, -2, 8, 1, 0, 0, 0, 0, 0};
      f = mk(v);
      run_frame(f, 1'b0);
      held = exp_q[0];
      for (int k = 0; k < 5; k++) begin
         i_score       = 8'sd99;
         i_score_valid = (k == 1 || k == 3);
         tick();
         i_score_valid = 1'b0;
         check("hold_valid", 32'(o_valid), 32'd1);
         check("hold_class", 32'(o_class), 32'(held.cls));
         check("hold_score", 32'(o_max_score), 32'(held.sc));
      end
      check("hold_ovf", 32'(o_overflow), 32'd1);
      pop_check("hold");
      v = '{7, 2, -3, 6, 7, 0, 1, -1, 5, 4};
      f = mk(v);
      exp_q.push_back(model(f));
      i_ready       = 1'b1;
      i_score       = f[0];
      i_score_valid = 1'b1;
      tick();
      check("hs_valid", 32'(o_valid), 32'd0);
      check("hs_busy", 32'(o_busy), 32'd1);
      check("hs_ovf_sticky", 32'(o_overflow), 32'd1);
      for (int i = 1; i < 10; i++) begin
         i_score = f[i];
         tick();
      end
      i_score_valid = 1'b0;
      check("carry_valid", 32'(o_valid), 32'd1);
      pop_check("carry");
      tick();

      // Abort after 4 scores with a coincident score, then a full frame
      for (int i = 0; i < 4; i++) begin
         i_score       = 8'sd50;
         i_score_valid = 1'b1;
         tick();
      end
      i_clear = 1'b1;
      tick();
      i_clear       = 1'b0;
      i_score_valid = 1'b0;
      check("clr_busy", 32'(o_busy), 32'd0);
      check("clr_valid", 32'(o_valid), 32'd0);
      check("clr_ovf", 32'(o_overflow), 32'd0);
      v = '{-1, 4, -7, 33, 12, 33, -100, 0, 2, 5};
      f = mk(v);
      run_frame(f, 1'b1);
      check("post_clr_valid", 32'(o_valid), 32'd1);
      pop_check("post_clr");
      tick();

`ifdef ARGMAX_SCORE_BUF_EN
      for (int i = 0; i < 10; i++) v[i] = 11 + i;
      f = mk(v);
      run_frame(f, 1'b1);
      pop_check("buf_frame");
      tick();
      for (int a = 0; a < 10; a++) begin
         i_rd_addr = 4'(a);
         tick();
         check("buf_rd", 32'(o_rd_score), 32'(11 + a));
      end
      i_rd_addr = 4'd12;
      tick();
      check("buf_rd_oor", 32'(o_rd_score), 32'd0);
`endif

      // Reset mid-frame clears outputs without waiting for a clock edge
      for (int i = 0; i < 3; i++) begin
         i_score       = 8'sd20;
         i_score_valid = 1'b1;
         tick();
      end
      i_score_valid = 1'b0;
      check("mid_busy", 32'(o_busy), 32'd1);
      resetn = 1'b0;
      #1;
      check("async_busy", 32'(o_busy), 32'd0);
      check("async_valid", 32'(o_valid), 32'd0);
      check("async_class", 32'(o_class), 32'd0);
      check("async_score", 32'(o_max_score), 32'd0);
      tick();
      resetn = 1'b1;
      tick();

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fc_argmax.md
Name: fc_argmax

Overview:
- Downstream consumer of the ternary fully-connected layer.
- Collects one saturated signed 8-bit score per output class, arriving as single-cycle valid pulses, and tracks the running maximum.
- After the last class score of a frame, presents the winning class index (predicted MNIST digit) and its score on a valid/ready output port.
- Output feeds the result register / UART reporter.

Parameters:
- NUM_CLASSES, 10, scores per frame; legal range 2..16.
- CLS_W, 4, width of class index and score counter; must satisfy 2^CLS_W >= NUM_CLASSES.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- i_score  in  8  signed class score, two's complement
- i_score_valid  in  1  one-cycle qualifier for i_score; no backpressure upstream
- i_clear  in  1  synchronous frame abort
- o_class  out  CLS_W  index of the maximum score
- o_max_score  out  8  the maximum score value
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts the result
- o_busy  out  1  high while a frame is partially accumulated (state ACCUM)
- o_overflow  out  1  sticky flag: a score was dropped

Behaviour:
- Reset: async on resetn low. All outputs 0, state IDLE, count 0, max register 0.
- States: IDLE, ACCUM, HOLD.
- IDLE, i_score_valid=1:
  - max<=i_score, idx<=0, cnt<=1, go to ACCUM.
- ACCUM, i_score_valid=1:
  - If $signed(i_score) > max (strict), then max<=i_score and idx<=cnt. Ties keep the earlier, lowest index.
  - cnt<=cnt+1.
  - If cnt==NUM_CLASSES-1, go to HOLD instead.
- ACCUM, no valid: hold all state. No timeout.
- Entering HOLD:
  - o_class and o_max_score are driven from the final compare result, including the last score.
  - o_valid rises on the same edge that samples the last score, so the result is visible the cycle after the last i_score_valid.
- HOLD:
  - o_valid, o_class and o_max_score are held stable until o_valid && i_ready.
  - On handshake without i_score_valid: o_valid<=0, go to IDLE.
  - On handshake with i_score_valid in the same cycle: the score is accepted as class 0 of the next frame (IDLE-load rule), o_valid<=0, go to ACCUM.
  - i_score_valid without i_ready: score dropped, o_overflow<=1, state unchanged.
- o_busy = (state==ACCUM), registered.
- o_overflow: set only in HOLD on a dropped score. Cleared only by i_clear or reset.
- i_clear has highest priority:
  - State to IDLE; cnt, idx and max to 0.
  - o_valid<=0 (a pending result is discarded), o_overflow<=0.
  - A coincident i_score_valid is ignored.
- Comparisons are signed 8-bit: -128 is the minimum and 127 the maximum. A frame of all -128 yields class 0 with score -128.
- Throughput: back-to-back scores accepted every cycle in IDLE and ACCUM.

Optional Feature:
- Macro ARGMAX_SCORE_BUF_EN.
- When defined:
  - Adds ports i_rd_addr (in, CLS_W) and o_rd_score (out, 8).
  - A NUM_CLASSES x 8 register file stores every accepted score of the current frame at index cnt.
  - o_rd_score <= buf[i_rd_addr] on each clock, giving 1-cycle read latency.
  - Contents are stable during HOLD. Reset and i_clear zero the buffer.
  - Out-of-range i_rd_addr returns 0.
- When undefined: the ports and buffer are absent; all other behaviour is identical.

Test Plan:
- Scores 0,10,20,...,90 back-to-back, i_ready=1 -> o_valid one cycle after the 10th score; o_class=9, o_max_score=90; o_valid drops after 1 cycle.
- Scores -5,-5,3,3,-128,127,127,0,0,0 -> o_class=5, o_max_score=127 (tie keeps lowest index).
- All ten scores = -128 -> o_class=0, o_max_score=-128.
- Complete a frame with i_ready=0 for 5 cycles and two extra scores injected -> result held stable, o_overflow=1; raise i_ready and present score 7 in the same cycle -> handshake; next frame starts with max=7, o_busy=1.
- Abort: 4 scores, then i_clear together with a score -> o_busy=0, cnt=0. Following full frame of 10 scores gives the correct argmax. Also reset mid-frame -> all outputs 0 immediately.
- ARGMAX_SCORE_BUF_EN: after frame 11,12,...,20, read addresses 0..9 -> o_rd_score 11..20 with 1-cycle latency; address 12 -> 0.
